symbol_chip_spreader: RTL
=========================

// Module: symbol_chip_spreader
// PURPOSE
//  DSSS spreader for the 2.4 GHz O-QPSK transmit path. It sits directly downstream of the inFIFO.
//  - Pops 4-bit symbols from the inFIFO.
//  - Maps each symbol to its 32-chip IEEE 802.15.4 PN sequence.
//  - Streams the chips out serially, one chip per CYCLES_PER_CHIP clocks, to the O-QPSK mapper.
//  - A one-entry prefetch buffer keeps consecutive symbols gapless.
// PARAMETERS
//  CYCLES_PER_CHIP  1   clock cycles each chip is held on outChip (legal range 1..16)
// PORTS
//  inClock         in   1  single clock; all logic on its rising edge
//  inReset         in   1  synchronous reset, active-high
//  inEnable        in   1  1 = run; 0 = freeze all state (no pops, chip timing held)
//  inData          in   4  symbol from inFIFO; valid the cycle after outReadEnable
//  inEmpty         in   1  inFIFO empty flag
//  outReadEnable   out  1  inFIFO pop strobe, one cycle per symbol
//  outChip         out  1  current chip value
//  outChipValid    out  1  outChip carries a valid chip
//  outSymbolStart  out  1  high during the cycles of chip c0 of every symbol
//  outBusy         out  1  buffer holds a symbol, a read is in flight, or state != IDLE
// BEHAVIOUR
//  Reset (synchronous, active-high):
//  - All outputs are 0.
//  - State = IDLE. Buffer is empty. No read is in flight. Chip index = 0. Cycle counter = 0.
//  - Reset mid-symbol aborts the symbol immediately: no further chips are sent.
//  - A symbol popped but not yet sent is discarded.
//  Chip table:
//  - Symbol 0 chips c0..c31 = 11011001110000110101001000101110.
//  - Symbols 1..7 = symbol 0 cyclically rotated right by 4*k chips. Example: symbol 1 = 1110 1101 1001 ...
//  - Symbols 8..15 = symbols 0..7 with every odd-index chip inverted.
//  - c0 is sent first.
//  Prefetch handshake (FIFO read latency = 1 cycle):
//  - outReadEnable is asserted in cycle T only if all of these hold: inEnable=1, inEmpty=0, buffer empty, no read in flight.
//  - inData is captured into the buffer at the end of cycle T+1.
//  - outReadEnable is never asserted while inEmpty=1.
//  - At most one read is outstanding at any time.
//  FSM states:
//  - IDLE: when the buffer is full, load it into the 32-bit chip shift register, clear the buffer, go to SPREAD.
//  - SPREAD: chip index 0..31; each chip is held for CYCLES_PER_CHIP cycles.
//  Transition on the last cycle of c31:
//  - Buffer full: load the next symbol. The next cycle shows the new c0 (gapless); the buffer is freed in the same cycle.
//  - Buffer empty: go to IDLE. outChipValid=0 the next cycle.
//  Latency:
//  - Starting from IDLE with an empty buffer: pop in cycle T, first valid chip c0 in cycle T+2.
//  Output rules:
//  - outChipValid = 1 exactly when state = SPREAD and inEnable = 1.
//  - outChip is held at the last value while frozen.
//  - outSymbolStart = 1 exactly when outChipValid = 1 and chip index = 0.
//  Freeze (inEnable=0):
//  - State, counters, buffer, and shift register all hold.
//  - outChipValid=0 and outReadEnable=0.
//  - A read already in flight still captures inData on the following cycle.
//  Counter widths:
//  - Chip index is 5 bits and wraps 31 -> 0 only on a symbol reload.
//  - Cycle counter is $clog2(CYCLES_PER_CHIP)+1 bits.
// TESTING
//  1. Preload symbol 0x0 in the FIFO, CYCLES_PER_CHIP=1.
//     -> outReadEnable pulses once; c0 appears 2 cycles later.
//     -> 32 valid chips 11011001110000110101001000101110, then outChipValid=0.
//  2. Single symbol 0x8.
//     -> 10001100100101100000011101111011.
//     -> outSymbolStart high only on the first chip.
//  3. Preload symbols 1, 4, 9 (CYCLES_PER_CHIP=1).
//     -> 96 contiguous valid chips with no gap.
//     -> outSymbolStart at chip offsets 0, 32, 64.
//     -> exactly 3 pops.
//  4. CYCLES_PER_CHIP=4, symbol 0x2.
//     -> each chip is held 4 cycles; 128 valid cycles.
//     -> sequence starts 00101110 (symbol 0 rotated right by 8).
//  5. inEnable=0 for 10 cycles at chip 12 of symbol 0x0.
//     -> outChipValid=0 and no pops during the freeze.
//     -> the stream resumes at chip 12; total still 32 chips.
//  6. Assert inReset at chip 20 with one symbol buffered.
//     -> the next cycle shows all outputs 0.
//     -> with an empty FIFO afterwards, no further chips or pops.

Source files
------------

// File: rtl/symbol_chip_spreader_if.sv
// Symbol/chip stream bundle between the inFIFO, the spreader and the O-QPSK mapper.
// The master side feeds symbols and run control; the slave side is the spreader.
interface symbol_chip_spreader_if;
  logic       inEnable;
  logic [3:0] inData;
  logic       inEmpty;
  logic       outReadEnable;
  logic       outChip;
  logic       outChipValid;
  logic       outSymbolStart;
  logic       outBusy;

  modport master (
    output inEnable, inData, inEmpty,
    input  outReadEnable, outChip, outChipValid, outSymbolStart, outBusy
  );

  modport slave (
    input  inEnable, inData, inEmpty,
    output outReadEnable, outChip, outChipValid, outSymbolStart, outBusy
  );
endinterface

// File: rtl/symbol_chip_spreader.sv
// DSSS spreader: pops 4-bit symbols from the inFIFO, maps each to its 32-chip
// 802.15.4 PN sequence and streams the chips serially, c0 first. A one-entry
// prefetch buffer keeps back-to-back symbols gapless.
module symbol_chip_spreader #(
  parameter int CYCLES_PER_CHIP = 1
) (
  input logic                   inClock,
  input logic                   inReset,
  symbol_chip_spreader_if.slave bus
);

  localparam int                CNT_W      = $clog2(CYCLES_PER_CHIP) + 1;
  localparam logic [CNT_W-1:0]  LAST_CYCLE = CNT_W'(CYCLES_PER_CHIP - 1);
  // Symbol 0 with c0 in bit 31, so the chip on air is always the MSB.
  localparam logic [31:0]       BASE_CHIPS = 32'hD9C3_522E;
  // Odd chip indices sit on even bit positions in the MSB-first layout.
  localparam logic [31:0]       ODD_MASK   = 32'h5555_5555;

  typedef enum logic {IDLE, SPREAD} stateT;

  // Symbol k (k<8) is symbol 0 rotated right by 4k chips; symbols 8..15 also
  // invert every odd-index chip.
  function automatic logic [31:0] chipsFor(input logic [3:0] symbol);
    logic [63:0] doubled;
    logic [31:0] rotated;
    doubled = {BASE_CHIPS, BASE_CHIPS};
    rotated = doubled[{1'b0, symbol[2:0], 2'b00} +: 32];
    if (symbol[3]) rotated = rotated ^ ODD_MASK;
    return rotated;
  endfunction

  stateT            state;
  logic [31:0]      shiftReg;
  logic [3:0]       buffer;
  logic             bufFull;
  logic             readInFlight;
  logic [4:0]       chipIndex;
  logic [CNT_W-1:0] cycleCount;

  logic       haveNext;
  logic [3:0] nextSymbol;
  logic       lastCycle;
  logic       endOfSymbol;
  logic       loadSymbol;
  logic       popNow;

  // A symbol arriving from the FIFO this cycle is used directly, bypassing the
  // buffer, so an idle spreader starts c0 two cycles after the pop and a read
  // landing on the last cycle of c31 still keeps the stream gapless.
  assign haveNext    = bufFull | readInFlight;
  assign nextSymbol  = bufFull ? buffer : bus.inData;
  assign lastCycle   = (cycleCount == LAST_CYCLE);
  assign endOfSymbol = (state == SPREAD) && lastCycle && (chipIndex == 5'd31);
  assign loadSymbol  = bus.inEnable && haveNext && ((state == IDLE) || endOfSymbol);
  assign popNow      = bus.inEnable && !bus.inEmpty && !bufFull && !readInFlight && !inReset;

  assign bus.outReadEnable  = popNow;
  assign bus.outChip        = shiftReg[31];
  assign bus.outChipValid   = (state == SPREAD) && bus.inEnable;
  assign bus.outSymbolStart = bus.outChipValid && (chipIndex == 5'd0);
  assign bus.outBusy        = bufFull || readInFlight || (state != IDLE);

  // Prefetch buffer, read tracking and chip sequencer; everything holds while
  // inEnable is low except the capture of a read already in flight.
  // NOTE: state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge inClock) begin
    if (inReset) begin
      // NOTE: buffer and shift register are cleared too, so a symbol popped
      // before reset can never leak chips afterwards.
      state        <= IDLE;
      shiftReg     <= '0;
      buffer       <= '0;
      bufFull      <= 1'b0;
      readInFlight <= 1'b0;
      chipIndex    <= '0;
      cycleCount   <= '0;
    end else begin
      readInFlight <= popNow;

      if (loadSymbol) begin
        bufFull <= 1'b0;
      end else if (readInFlight) begin
        buffer  <= bus.inData;
        bufFull <= 1'b1;
      end

      if (loadSymbol) begin
        shiftReg   <= chipsFor(nextSymbol);
        chipIndex  <= '0;
        cycleCount <= '0;
        state      <= SPREAD;
      end else if ((state == SPREAD) && bus.inEnable) begin
        if (lastCycle) begin
          cycleCount <= '0;
          if (chipIndex == 5'd31) begin
            state <= IDLE;
          end else begin
            shiftReg  <= shiftReg << 1;
            chipIndex <= chipIndex + 5'd1;
          end
        end else begin
          cycleCount <= cycleCount + 1'b1;
        end
      end
    end
  end

endmodule
